calc1_req_driver: RTL

- Upstream request sequencer for one calc1 request port.
- Queues operations {cmd, operand1, operand2} from a stimulus or sequence source and serialises each onto the calc1 two-cycle request protocol.
- Waits for the calc1 response with a timeout, then returns the status and result through a valid/ready handshake.
- Only one operation is outstanding per port at a time.

---
 rtl/calc1_req_driver.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/calc1_req_driver.sv
// ---------------------------------------------------------------------------
// calc1_req_driver
//   Upstream request sequencer for one calc1 request port. Operations
//   {cmd, operand1, operand2} are queued in a small FIFO and serialised one at
//   a time onto the calc1 two-cycle request protocol (cmd+operand1, then
//   operand2). The driver then waits for the calc1 response (bounded by
//   TIMEOUT cycles) and presents status/result on a valid/ready handshake.
//
// Parameters
//   DEPTH    operation FIFO depth (power of 2, >= 2)
//   TIMEOUT  WAIT_RESP cycles without a response before status 3 is reported
//
// Ports
//   c_clk, reset                 clock (rising edge), async active-high reset
//   op_valid/op_ready            operation enqueue handshake
//   op_cmd, op_data1, op_data2   operation fields
//   req_cmd_out, req_data_out    calc1 request bus
//   calc_resp_in, calc_data_in   calc1 response bus
//   rsp_valid/rsp_ready          result handshake
//   rsp_status, rsp_data         captured response (status 3 = driver timeout)
//   fifo_level                   number of queued operations
//   busy                         FSM is not idle
//   err_spurious                 sticky: response seen outside WAIT_RESP
// ---------------------------------------------------------------------------
module calc1_req_driver #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     c_clk,
   input  logic                     reset,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [3:0]               op_cmd,
   input  logic [31:0]              op_data1,
   input  logic [31:0]              op_data2,
   output logic [3:0]               req_cmd_out,
   output logic [31:0]              req_data_out,
   input  logic [1:0]               calc_resp_in,
   input  logic [31:0]              calc_data_in,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [1:0]               rsp_status,
   output logic [31:0]              rsp_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy,
   output logic                     err_spurious
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int EW = 4 + 32 + 32;

   typedef enum logic [2:0] {
      IDLE,
      SEND_OP1,
      SEND_OP2,
      WAIT_RESP,
      RESP_HOLD
   } state_t;

   state_t           state_q, state_d;

   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    count_q, count_d;
   logic             full_q;

   logic [3:0]       cur_cmd_q;
   logic [31:0]      cur_data1_q, cur_data2_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       rsp_status_q;
   logic [31:0]      rsp_data_q;
   logic             err_spurious_q;

   logic             push, pop, resp_seen, timed_out;

   // cmd 0 is a no-op: the handshake completes but nothing is stored
   assign op_ready  = !full_q;
   assign push      = op_valid && op_ready && (op_cmd != 4'd0);
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign resp_seen = (calc_resp_in != 2'd0);
   assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage carries no reset; the pointers and count define validity
   always_ff @(posedge c_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {op_cmd, op_data1, op_data2};
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == LW'(DEPTH));
      end
   end

   // FSM state register
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (pop) state_d = SEND_OP1;
         SEND_OP1:  state_d = SEND_OP2;
         SEND_OP2:  state_d = WAIT_RESP;
         WAIT_RESP: if (resp_seen || timed_out) state_d = RESP_HOLD;
         RESP_HOLD: if (rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Operation register, wait counter and captured response
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         cur_cmd_q    <= '0;
         cur_data1_q  <= '0;
         cur_data2_q  <= '0;
         cnt_q        <= '0;
         rsp_status_q <= '0;
         rsp_data_q   <= '0;
      end else begin
         if (pop) begin
            {cur_cmd_q, cur_data1_q, cur_data2_q} <= mem[rd_ptr_q];
         end
         if (state_q == SEND_OP2) begin
            cnt_q <= '0;
         end else if (state_q == WAIT_RESP) begin
            // a response arriving on the timeout cycle takes priority
            if (resp_seen) begin
               rsp_status_q <= calc_resp_in;
               rsp_data_q   <= calc_data_in;
            end else if (timed_out) begin
               rsp_status_q <= 2'd3;
               rsp_data_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset)                                 err_spurious_q <= 1'b0;
      else if (resp_seen && state_q != WAIT_RESP) err_spurious_q <= 1'b1;
   end

   // Request bus is a pure decode of state; idle and waiting cycles drive 0
   always_comb begin
      req_cmd_out  = 4'd0;
      req_data_out = 32'd0;
      case (state_q)
         SEND_OP1: begin
            req_cmd_out  = cur_cmd_q;
            req_data_out = cur_data1_q;
         end
         SEND_OP2: req_data_out = cur_data2_q;
         default: ;
      endcase
   end

   assign rsp_valid    = (state_q == RESP_HOLD);
   assign rsp_status   = rsp_status_q;
   assign rsp_data     = rsp_data_q;
   assign fifo_level   = count_q;
   assign busy         = (state_q != IDLE);
   assign err_spurious = err_spurious_q;

endmodule
